// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - SPECIAL_* : function codes of the HI/LO-related SPECIAL instructions
//   - state_e   : sequencer states (IDLE, MUL, DIV, FIX)
//   - op_is_signed : true for the signed arithmetic variants (MULT, DIV)
package muldiv_unit_pkg;

  localparam logic [5:0] SPECIAL_MFHI  = 6'h10;
  localparam logic [5:0] SPECIAL_MTHI  = 6'h11;
  localparam logic [5:0] SPECIAL_MFLO  = 6'h12;
  localparam logic [5:0] SPECIAL_MTLO  = 6'h13;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic op_is_signed(input logic [5:0] op);
    return (op == SPECIAL_MULT) || (op == SPECIAL_DIV);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negator.
//   in_x      : value to process
//   signed_en : treat in_x as signed; its MSB then requests negation
//   force_neg : negate unconditionally (used for result sign correction)
//   out_x     : |in_x| when signed_en, or -in_x when force_neg, else in_x
//   sign      : sign bit of in_x when signed_en, else 0
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_x,
  input  logic             signed_en,
  input  logic             force_neg,
  output logic [WIDTH-1:0] out_x,
  output logic             sign
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign sign  = signed_en & in_x[WIDTH-1];
  assign out_x = (sign | force_neg) ? (~in_x + ONE) : in_x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   w_clk, w_rst_n        : clock, asynchronous active-low reset
//   w_op_code_6           : SPECIAL function code
//   w_start, w_flush      : launch strobe (IDLE only), abort in-flight op
//   w_input1_x/w_input2_x : rs / rt operands
//   w_busy, w_done        : op in progress, one-cycle completion pulse
//   w_output_x            : HI for MFHI, LO for MFLO, else 0 (combinational)
//   w_hi_x, w_lo_x        : current HI / LO
// Multiplies are radix-2 shift-add and divides are restoring, both on
// magnitudes; the sign is applied in the FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic [5:0]       w_op_code_6,
  input  logic             w_start,
  input  logic             w_flush,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  output logic             w_busy,
  output logic             w_done,
  output logic [WIDTH-1:0] w_output_x,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;     // multiplicand magnitude
  logic [WIDTH-1:0]     op_b_q, op_b_d;     // multiplier shift reg / divisor
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_hi_q, sign_hi_d, sign_lo_q, sign_lo_d;
  logic                 is_div_q, is_div_d;
  logic                 busy_q, busy_d, done_q, done_d;

  // The two operand negators take the raw operands in IDLE and the
  // accumulator halves in FIX, so one pair serves both jobs.
  logic             in_fix;
  logic [WIDTH-1:0] a_in, b_in, a_out, b_out;
  logic             a_sign, b_sign;

  assign in_fix = (state_q == ST_FIX);
  assign a_in   = in_fix ? acc_q[2*WIDTH-1:WIDTH] : w_input1_x;
  assign b_in   = in_fix ? acc_q[WIDTH-1:0]       : w_input2_x;

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (
    .in_x      (a_in),
    .signed_en (!in_fix && op_is_signed(w_op_code_6)),
    .force_neg (in_fix && sign_hi_q),
    .out_x     (a_out),
    .sign      (a_sign)
  );

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (
    .in_x      (b_in),
    .signed_en (!in_fix && op_is_signed(w_op_code_6)),
    .force_neg (in_fix && sign_lo_q),
    .out_x     (b_out),
    .sign      (b_sign)
  );

  // Iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   fix_hi;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (op_b_q[0] ? op_a_q : {WIDTH{1'b0}})};
  // Partial remainder shifted left one bit, minus the divisor; bit WIDTH
  // set means the subtraction borrowed and the quotient bit is 0.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, op_b_q};

  // Negating a 2*WIDTH product half by half: the low half is -lo, the high
  // half is ~hi plus the carry out of ~lo+1, which is 1 only when lo == 0.
  assign fix_hi = (!is_div_q && sign_hi_q && (|acc_q[WIDTH-1:0]))
                  ? ~acc_q[2*WIDTH-1:WIDTH] : a_out;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cnt_d     = cnt_q;
    sign_hi_d = sign_hi_q;
    sign_lo_d = sign_lo_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_start && !w_flush) begin
          case (w_op_code_6)
            SPECIAL_MULT, SPECIAL_MULTU: begin
              op_a_d    = a_out;
              op_b_d    = b_out;
              acc_d     = '0;
              cnt_d     = '0;
              sign_hi_d = a_sign ^ b_sign;
              sign_lo_d = a_sign ^ b_sign;
              is_div_d  = 1'b0;
              state_d   = ST_MUL;
            end
            SPECIAL_DIV, SPECIAL_DIVU: begin
              op_a_d    = a_out;
              op_b_d    = b_out;
              acc_d     = {{WIDTH{1'b0}}, a_out};
              cnt_d     = '0;
              sign_hi_d = a_sign;
              // A zero divisor leaves an all-ones quotient that must not be
              // negated.
              sign_lo_d = (a_sign ^ b_sign) & (|w_input2_x);
              is_div_d  = 1'b1;
              state_d   = ST_DIV;
            end
            SPECIAL_MTHI: hi_d = w_input1_x;
            SPECIAL_MTLO: lo_d = w_input1_x;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (w_flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
          op_b_d = op_b_q >> 1;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = ST_FIX;
        end
      end
      ST_DIV: begin
        if (w_flush) begin
          state_d = ST_IDLE;
        end else begin
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!w_flush) begin
          hi_d   = fix_hi;
          lo_d   = b_out;
          done_d = 1'b1;
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_q     <= '0;
      sign_hi_q <= 1'b0;
      sign_lo_q <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_q     <= cnt_d;
      sign_hi_q <= sign_hi_d;
      sign_lo_q <= sign_lo_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    w_output_x = '0;
    if (w_op_code_6 == SPECIAL_MFHI)      w_output_x = hi_q;
    else if (w_op_code_6 == SPECIAL_MFLO) w_output_x = lo_q;
  end

  assign w_busy = busy_q;
  assign w_done = done_q;
  assign w_hi_x = hi_q;
  assign w_lo_x = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32): directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         w_clk;
  logic         w_rst_n;
  logic [5:0]   w_op_code_6;
  logic         w_start;
  logic         w_flush;
  logic [W-1:0] w_input1_x;
  logic [W-1:0] w_input2_x;
  logic         w_busy;
  logic         w_done;
  logic [W-1:0] w_output_x;
  logic [W-1:0] w_hi_x;
  logic [W-1:0] w_lo_x;

  muldiv_unit #(.WIDTH(W)) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_op_code_6 (w_op_code_6),
    .w_start     (w_start),
    .w_flush     (w_flush),
    .w_input1_x  (w_input1_x),
    .w_input2_x  (w_input2_x),
    .w_busy      (w_busy),
    .w_done      (w_done),
    .w_output_x  (w_output_x),
    .w_hi_x      (w_hi_x),
    .w_lo_x      (w_lo_x)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the architectural special cases.
  function automatic void model_op(input logic [5:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sb, sp, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = hi_m;
    lo = lo_m;
    case (op)
      SPECIAL_MULT: begin
        sp = sa * sb;
        {hi, lo} = sp;
      end
      SPECIAL_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
      end
      SPECIAL_DIV: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = '0; lo = 32'h8000_0000;
        end else begin
          q = sa / sb; r = sa % sb;
          hi = r[W-1:0]; lo = q[W-1:0];
        end
      end
      SPECIAL_DIVU: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else begin
          hi = a % b; lo = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    w_op_code_6 = op;
    w_input1_x  = a;
    w_input2_x  = b;
    w_start     = 1'b1;
    @(posedge w_clk);
    @(negedge w_clk);
    w_start = 1'b0;
  endtask

  // Counts clock edges since the start edge until w_done is seen.
  task automatic wait_done(input int from_edges, output int edges);
    edges = from_edges;
    while (!w_done && edges < 200) begin
      @(negedge w_clk);
      edges++;
    end
  endtask

  task automatic run_arith(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int e;
    model_op(op, a, b, eh, el);
    launch(op, a, b);
    check("busy_after_start", w_busy, 1);
    wait_done(0, e);
    check("latency", e, W + 1);
    check("hi", w_hi_x, eh);
    check("lo", w_lo_x, el);
    check("busy_at_done", w_busy, 0);
    hi_m = eh;
    lo_m = el;
    $display("op=%h a=%h b=%h hi=%h lo=%h edges=%0d", op, a, b, w_hi_x, w_lo_x, e);
  endtask

  task automatic do_mt(input logic [5:0] op, input logic [W-1:0] v);
    launch(op, v, '0);
    if (op == SPECIAL_MTHI) hi_m = v;
    else                    lo_m = v;
    check("mt_busy", w_busy, 0);
    check("mt_done", w_done, 0);
    check("mt_hi", w_hi_x, hi_m);
    check("mt_lo", w_lo_x, lo_m);
    $display("op=%h v=%h hi=%h lo=%h", op, v, w_hi_x, w_lo_x);
  endtask

  task automatic read_check();
    w_start = 1'b0;
    w_op_code_6 = SPECIAL_MFHI;
    #1 check("mfhi", w_output_x, hi_m);
    w_op_code_6 = SPECIAL_MFLO;
    #1 check("mflo", w_output_x, lo_m);
    w_op_code_6 = SPECIAL_MULT;
    #1 check("out_other", w_output_x, 0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0]   ops [6];
    logic [W-1:0] eh, el, ra, rb;
    int e;
    bit saw_done;
    ops[0] = SPECIAL_MULT;  ops[1] = SPECIAL_MULTU; ops[2] = SPECIAL_DIV;
    ops[3] = SPECIAL_DIVU;  ops[4] = SPECIAL_MTHI;  ops[5] = SPECIAL_MTLO;

    w_rst_n = 1'b0; w_op_code_6 = '0; w_start = 1'b0; w_flush = 1'b0;
    w_input1_x = '0; w_input2_x = '0;
    repeat (3) @(negedge w_clk);
    check("rst_hi", w_hi_x, 0);
    check("rst_lo", w_lo_x, 0);
    check("rst_busy", w_busy, 0);
    check("rst_done", w_done, 0);
    w_rst_n = 1'b1;
    @(negedge w_clk);

    // Directed arithmetic cases.
    run_arith(SPECIAL_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
    @(negedge w_clk);
    check("done_pulse", w_done, 0);
    run_arith(SPECIAL_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    run_arith(SPECIAL_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    run_arith(SPECIAL_DIVU,  32'd7, 32'd2);
    read_check();
    run_arith(SPECIAL_DIVU,  32'd5, 32'd0);
    run_arith(SPECIAL_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge w_clk);

    // MTHI / MTLO and immediate reads.
    do_mt(SPECIAL_MTHI, 32'h1234_5678);
    read_check();
    @(negedge w_clk);
    do_mt(SPECIAL_MTLO, 32'hCAFE_F00D);
    read_check();
    @(negedge w_clk);

    // Start ignored while busy; reads during busy return the old value.
    model_op(SPECIAL_DIV, 32'd1000, 32'hFFFF_FFFD, eh, el);
    launch(SPECIAL_DIV, 32'd1000, 32'hFFFF_FFFD);
    repeat (4) @(negedge w_clk);
    w_op_code_6 = SPECIAL_MULT; w_input1_x = 32'd9; w_input2_x = 32'd9; w_start = 1'b1;
    @(negedge w_clk);
    w_start = 1'b0;
    w_op_code_6 = SPECIAL_MFHI;
    #1 check("mfhi_busy", w_output_x, hi_m);
    wait_done(5, e);
    check("busy_start_latency", e, W + 1);
    check("busy_start_hi", w_hi_x, eh);
    check("busy_start_lo", w_lo_x, el);
    hi_m = eh; lo_m = el;
    @(negedge w_clk);
    check("busy_start_no_relaunch", w_busy, 0);

    // Flush during iteration 10 of MULT.
    launch(SPECIAL_MULT, 32'd123, 32'd456);
    repeat (9) @(negedge w_clk);
    w_flush = 1'b1;
    @(negedge w_clk);
    w_flush = 1'b0;
    check("flush_mul_busy", w_busy, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (w_done) saw_done = 1'b1;
      @(negedge w_clk);
    end
    check("flush_mul_no_done", saw_done, 0);
    check("flush_mul_hi", w_hi_x, hi_m);
    check("flush_mul_lo", w_lo_x, lo_m);

    // Flush in the FIX cycle.
    launch(SPECIAL_DIVU, 32'd99, 32'd7);
    repeat (W) @(negedge w_clk);
    check("fix_busy", w_busy, 1);
    w_flush = 1'b1;
    @(negedge w_clk);
    w_flush = 1'b0;
    check("flush_fix_done", w_done, 0);
    check("flush_fix_busy", w_busy, 0);
    check("flush_fix_hi", w_hi_x, hi_m);
    check("flush_fix_lo", w_lo_x, lo_m);

    // Flush in IDLE suppresses a same-cycle start.
    w_flush = 1'b1;
    launch(SPECIAL_MTHI, 32'hDEAD_BEEF, '0);
    w_flush = 1'b0;
    check("idle_flush_hi", w_hi_x, hi_m);
    check("idle_flush_busy", w_busy, 0);

    // Unknown opcode with start is ignored.
    launch(6'h20, 32'd3, 32'd4);
    check("bad_op_busy", w_busy, 0);
    check("bad_op_hi", w_hi_x, hi_m);
    check("bad_op_lo", w_lo_x, lo_m);
    #1 check("bad_op_out", w_output_x, 0);
    @(negedge w_clk);

    // Asynchronous reset at iteration 20 of a DIV.
    launch(SPECIAL_DIV, 32'hFFFF_0000, 32'd3);
    repeat (19) @(negedge w_clk);
    #2 w_rst_n = 1'b0;
    #1;
    check("arst_hi", w_hi_x, 0);
    check("arst_lo", w_lo_x, 0);
    check("arst_busy", w_busy, 0);
    check("arst_done", w_done, 0);
    hi_m = '0; lo_m = '0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    @(negedge w_clk);
    run_arith(SPECIAL_MULT, 32'd3, 32'd4);

    // Randomized operations, launched back-to-back from the done cycle.
    for (int i = 0; i < 30; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      case ($urandom_range(0, 5))
        0: run_arith(ops[0], ra, rb);
        1: run_arith(ops[1], ra, rb);
        2: run_arith(ops[2], ra, rb);
        3: run_arith(ops[3], ra, rb);
        4: begin do_mt(ops[4], ra); @(negedge w_clk); end
        default: begin do_mt(ops[5], ra); @(negedge w_clk); end
      endcase
      read_check();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit with architectural HI/LO registers. It is the sequential successor to the combinational ALU's MULT/MULTU/DIV/DIVU/MFHI/MFLO paths. It sits beside the ALU in the execute stage. The pipeline launches an operation with a start strobe, stalls on `w_busy`, and reads results through MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand, HI and LO width.
- `w_clk` in 1: clock, rising edge.
- `w_rst_n` in 1: asynchronous, active-low reset.
- `w_op_code_6` in 6: operation, using the shared ISA codes SPECIAL_MULT, SPECIAL_MULTU, SPECIAL_DIV, SPECIAL_DIVU, SPECIAL_MFHI, SPECIAL_MFLO, SPECIAL_MTHI, SPECIAL_MTLO.
- `w_start` in 1: launch strobe, sampled only in IDLE.
- `w_flush` in 1: abort the in-flight operation.
- `w_input1_x` in WIDTH: rs (multiplicand or dividend; MTHI/MTLO source).
- `w_input2_x` in WIDTH: rt (multiplier or divisor).
- `w_busy` out 1: an iterative operation is in progress.
- `w_done` out 1: one-cycle pulse on the cycle HI/LO are updated by MULT*/DIV*.
- `w_output_x` out WIDTH: HI for MFHI, LO for MFLO, 0 otherwise.
- `w_hi_x`, `w_lo_x` out WIDTH: current HI and LO register values.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `w_start` + MULT/MULTU:
  - Latch the operands. For the signed variant, latch absolute values plus the result sign.
  - Clear the 2·WIDTH accumulator and the iteration counter; go to MUL.
- IDLE + `w_start` + DIV/DIVU:
  - Latch the operands (absolute values for the signed variant); go to DIV.
  - The quotient sign is the XOR of the operand signs. The remainder sign is the dividend's sign.
- MUL: radix-2 shift-add, one multiplier bit per cycle, WIDTH cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Write HI (product upper half or remainder) and LO (product lower half or quotient).
  - Pulse `w_done`; return to IDLE.
- Arithmetic is modulo 2^WIDTH per half.
  - Signed DIV of most-negative by −1: LO = most-negative, HI = 0.
- Divide by zero (DIV or DIVU):
  - Iterations still run for WIDTH cycles.
  - Result: HI = `w_input1_x` as latched, LO = all ones.
- IDLE + `w_start` + MTHI/MTLO:
  - Write `w_input1_x` to HI or LO at the next edge.
  - No busy, no done.
- MFHI/MFLO are combinational reads of the registers, valid in any state.
  - While busy they return the pre-operation value; the pipeline must stall on `w_busy`.
- `w_start` while busy is ignored, whatever the opcode.
- Opcodes outside the set above, with `w_start`, are ignored; the unit stays in IDLE.
- `w_flush` in MUL, DIV or FIX:
  - Return to IDLE at the next edge. HI/LO are unchanged and `w_done` is not pulsed.
  - Flush has priority over completion in FIX.
- `w_flush` in IDLE:
  - No effect. It also suppresses a same-cycle `w_start`.
- Reset (asynchronous, any time, including mid-operation):
  - State IDLE; HI = LO = 0.
  - `w_busy` = 0, `w_done` = 0.
  - Accumulator and counter cleared.

## Timing
- Start accepted at edge 0.
- Iterations occupy edges 1..WIDTH; FIX occurs at edge WIDTH+1.
- `w_busy` is high from after edge 0 until after edge WIDTH+1: WIDTH+1 cycles.
- `w_done` and the new HI/LO are visible in the cycle after edge WIDTH+1: latency WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back: a new `w_start` is accepted in the `w_done` cycle.
- MTHI/MTLO: 1-cycle write latency.
- MFHI/MFLO: 0-cycle (combinational) read.
- All outputs are registered except `w_output_x`.

## Structure
- Shared package / `isa_codes.v`:
  - Add SPECIAL_MTHI and SPECIAL_MTLO.
  - Add the state encoding constants (IDLE, MUL, DIV, FIX).
- Sub-module `muldiv_abs`: WIDTH-parametrised absolute value plus sign extraction. It is instantiated twice for the operands and reused for FIX negation.
- Datapath (accumulator, shift registers, counter) and FSM live in `muldiv_unit`; target ~250 lines.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002: HI=0xFFFFFFFF, LO=0xFFFFFFFE; `w_done` 33 cycles after start. The same operands with MULTU: HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) ÷ 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 2: LO=3, HI=1. MFLO afterwards returns LO on `w_output_x`.
- DIVU 5 ÷ 0: HI=5, LO=0xFFFFFFFF. DIV 0x80000000 ÷ 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI 0x12345678 then MFHI next cycle returns 0x12345678. A MULT start 5 cycles into a busy DIV is ignored; the DIV result is unaffected.
- Flush at iteration 10 of MULT: `w_busy` is low next cycle, no `w_done`, HI/LO keep their prior values. Flush in the FIX cycle also suppresses the write.
- `w_rst_n` low mid-DIV (iteration 20): HI=LO=0 and `w_busy`=0 immediately, with no clock edge. After release, a fresh MULT 3 × 4 gives LO=12, HI=0.
